// File: rtl/serial_pkg.sv
// serial_pkg: shared arbiter state encoding, default word width and index-width helper
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;
  localparam int DEF_WIDTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/serial_strobe_gen.sv
// serial_strobe_gen: divides the system clock into a one-cycle serial strobe every STB_DIV cycles
module serial_strobe_gen
  import serial_pkg::*;
#(
  parameter int STB_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_stb
);
  localparam int CW = clog2(STB_DIV);
  localparam logic [CW-1:0] LAST = CW'(STB_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    stb_d = (cnt_q == LAST);
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  assign o_stb = stb_q;
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sequencer sharing one shift register among NUM_REQ clients
// Define SR_ARB_TIMEOUT_EN to abort transfers stuck in the wait states after TIMEOUT cycles.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STB_DIV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_sr_clk_stb,
  output logic                     o_sr_start_stb,
  output logic [WIDTH-1:0]         o_sr_data,
  input  logic                     i_sr_busy,
  output logic                     o_error
);
  localparam int IW = clog2(NUM_REQ);
  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, idx_q, idx_d, pick;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               start_q, start_d, err_q, err_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               arb_go, fin, tmo;
  // Descending offsets so the closest requester after ptr wins; ptr itself is last.
  always_comb begin
    pick = ptr_q;
    for (int k = NUM_REQ; k >= 1; k--)
      if (i_req[(int'(ptr_q) + k) % NUM_REQ]) pick = IW'((int'(ptr_q) + k) % NUM_REQ);
  end
  assign arb_go = (state_q == IDLE) && |i_req && !i_sr_busy;
  assign fin    = (state_q == WAIT_DONE) && !i_sr_busy;
`ifdef SR_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;
  assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  always_comb cnt_d = waiting ? cnt_q + 1'b1 : '0;
  assign tmo = waiting && !fin && (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = arb_go ? START : IDLE;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tmo ? IDLE : (i_sr_busy ? WAIT_DONE : WAIT_BUSY);
      WAIT_DONE: state_d = (fin || tmo) ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    grant_d = arb_go ? NUM_REQ'(1) << pick : '0;
    done_d  = fin ? NUM_REQ'(1) << idx_q : '0;
    start_d = (state_q == START);
    err_d   = tmo;
    idx_d   = arb_go ? pick : idx_q;
    data_d  = arb_go ? i_req_data[int'(pick)*WIDTH +: WIDTH] : data_q;
    ptr_d   = (fin || tmo) ? idx_q : ptr_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      start_q <= start_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  serial_strobe_gen #(.STB_DIV(STB_DIV)) u_stb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_stb     (o_sr_clk_stb)
  );
  assign o_grant        = grant_q;
  assign o_done         = done_q;
  assign o_sr_start_stb = start_q;
  assign o_sr_data      = data_q;
  assign o_error        = err_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed and randomized checks of serial_tx_arbiter against a transaction-level model
module tb_serial_tx_arbiter;
  localparam int TMO = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        busy = 1'b0;
  logic [3:0]  a_grant, a_done, b_grant, b_done;
  logic        a_stb, a_start, a_error, b_stb, b_start, b_error;
  logic [7:0]  a_data, b_data;

  serial_tx_arbiter #(.NUM_REQ(4), .WIDTH(8), .STB_DIV(4), .TIMEOUT(TMO)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_req_data(req_data),
    .o_grant(a_grant), .o_done(a_done), .o_sr_clk_stb(a_stb), .o_sr_start_stb(a_start),
    .o_sr_data(a_data), .i_sr_busy(busy), .o_error(a_error));
  serial_tx_arbiter #(.NUM_REQ(4), .WIDTH(8), .STB_DIV(1), .TIMEOUT(TMO)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_req_data(req_data),
    .o_grant(b_grant), .o_done(b_done), .o_sr_clk_stb(b_stb), .o_sr_start_stb(b_start),
    .o_sr_data(b_data), .i_sr_busy(busy), .o_error(b_error));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  // Transaction-level model: is the arbiter free, who owns it, when was it granted.
  bit         free = 1'b1, rose = 1'b0;
  int         ptr = 0, cur = 0, t_grant = 0, nstb = 0;
  logic [3:0] eg, ed;
  logic       es, ee;
  logic [7:0] edata = '0;
  bit         auto_sr = 1'b1;
  int         sr_wait = 0, sr_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int k, j;
    cyc++;
    eg = '0; ed = '0; es = 1'b0; ee = 1'b0;
    if (!rst_n) begin
      free = 1'b1; ptr = 0; edata = '0; nstb = 0;
      return;
    end
    nstb++;
    if (free) begin
      if (req != 0 && !busy) begin
        for (k = 1; k <= 4; k++) begin
          j = (ptr + k) % 4;
          if (req[j]) break;
        end
        cur = j; eg = 4'(1 << j); edata = req_data[j*8 +: 8];
        free = 1'b0; t_grant = cyc; rose = 1'b0;
      end
    end else if (cyc == t_grant + 1) es = 1'b1;
    else begin
      k = cyc - t_grant - 1;
      if (rose && !busy) begin
        ed = 4'(1 << cur); ptr = cur; free = 1'b1;
      end else begin
        if (!rose) rose = busy;
`ifdef SR_ARB_TIMEOUT_EN
        if (k == TMO) begin ee = 1'b1; ptr = cur; free = 1'b1; end
`endif
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("a_grant", 32'(a_grant), 32'(eg));
    chk("a_done", 32'(a_done), 32'(ed));
    chk("a_start", 32'(a_start), 32'(es));
    chk("a_data", 32'(a_data), 32'(edata));
    chk("a_error", 32'(a_error), 32'(ee));
    chk("a_stb", 32'(a_stb), 32'(nstb > 0 && nstb % 4 == 0));
    chk("b_grant", 32'(b_grant), 32'(eg));
    chk("b_done", 32'(b_done), 32'(ed));
    chk("b_start", 32'(b_start), 32'(es));
    chk("b_data", 32'(b_data), 32'(edata));
    chk("b_error", 32'(b_error), 32'(ee));
    chk("b_stb", 32'(b_stb), 32'(nstb > 0));
    if (auto_sr) begin
      if (a_start) begin sr_wait = $urandom_range(2); sr_left = $urandom_range(8, 1); end
      if (sr_wait > 0) begin sr_wait--; busy = 1'b0; end
      else if (sr_left > 0) begin busy = 1'b1; sr_left--; end
      else busy = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; busy = 1'b0; sr_wait = 0; sr_left = 0;
    repeat (3) cycle();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < 200 && !free; i++) cycle();
    chk("drain", 32'(free), 32'd1);
  endtask

  task automatic rand_req();
    for (int i = 0; i < 4; i++)
      if (req[i]) begin
        if (a_grant[i] || $urandom_range(31) == 0) req[i] = 1'b0;
      end else begin
        req_data[i*8 +: 8] = 8'($urandom);
        if ($urandom_range(3) == 0) req[i] = 1'b1;
      end
  endtask

  initial begin
    int order[5];
    int ng, last_done;
    logic [7:0] s4, s1;
    order = '{1, 2, 3, 0, 1};
    do_reset();
    // Single request from client 2
    req_data = 32'h11A52233; req = 4'b0100;
    cycle();
    chk("t1_grant", 32'(a_grant), 32'h4);
    chk("t1_data", 32'(a_data), 32'hA5);
    req = '0;
    cycle();
    chk("t1_start", 32'(a_start), 32'h1);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (a_done != 0) break;
    end
    chk("t1_done", 32'(a_done), 32'h4);
    chk("t1_data_hold", 32'(a_data), 32'hA5);
    // All clients held: rotation from ptr 0, plus strobe pattern after reset
    do_reset();
    req = 4'b1111; req_data = $urandom;
    ng = 0; last_done = 0; s4 = '0; s1 = '0;
    for (int i = 0; i < 300 && ng < 5; i++) begin
      cycle();
      if (i < 8) begin s4[i] = a_stb; s1[i] = b_stb; end
      if (a_done != 0) last_done = cyc;
      if (a_grant != 0) begin
        chk("t2_order", 32'(oh(a_grant)), 32'(order[ng]));
        if (ng > 0) chk("t2_gap", 32'(cyc - last_done), 32'd1);
        ng++;
      end
    end
    chk("t2_count", 32'(ng), 32'd5);
    chk("t4_stb_div4", 32'(s4), 32'h88);
    chk("t4_stb_div1", 32'(s1), 32'hFF);
    // Reset while waiting for busy to fall
    do_reset();
    auto_sr = 1'b0; req_data = 32'h000000C3; req = 4'b0001;
    cycle();
    chk("t3_grant", 32'(a_grant), 32'h1);
    req = '0;
    cycle();
    busy = 1'b1;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1 chk("t3_rst_zero", {a_grant, a_done, a_start, a_error, a_data, a_stb, b_stb, b_data},
           32'h0);
    busy = 1'b0;
    repeat (2) cycle();
    @(negedge clk) rst_n = 1'b1;
    req = 4'b0011;
    cycle();
    chk("t3_regrant", 32'(a_grant), 32'h2);
    req = 4'b0001; auto_sr = 1'b1;
    repeat (2) cycle();
    drain();
    // Foreign busy blocks arbitration; withdrawn request is never served
    auto_sr = 1'b0; busy = 1'b1; req = 4'b0010;
    repeat (4) begin
      cycle();
      chk("t6_blocked", 32'(a_grant), 32'h0);
    end
    req = '0;
    cycle();
    busy = 1'b0;
    repeat (4) begin
      cycle();
      chk("t6_nogrant", 32'({a_grant[1], a_done[1]}), 32'h0);
    end
    // Busy stuck high after start
    req = 4'b0100;
    cycle();
    chk("t5_grant", 32'(a_grant), 32'h4);
    req = '0; busy = 1'b1;
    cycle();
`ifdef SR_ARB_TIMEOUT_EN
    for (int n = 1; n <= TMO; n++) begin
      cycle();
      if (n == TMO) chk("t5_error", 32'(a_error), 32'h1);
    end
    repeat (3) begin
      cycle();
      chk("t5_no_done", 32'(a_done), 32'h0);
    end
    busy = 1'b0;
    cycle();
`else
    repeat (40) cycle();
    chk("t5_no_abort", 32'({a_done, a_error}), 32'h0);
    busy = 1'b0;
    cycle();
    chk("t5_done", 32'(a_done), 32'h4);
`endif
    drain();
    // Randomized traffic
    auto_sr = 1'b1;
    repeat (3000) begin
      cycle();
      rand_req();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
